// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, ALU operation encodings and controller states.
package sisc_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_RR = 4'h1;
    localparam logic [3:0] OP_ALU_RI = 4'h2;
    localparam logic [3:0] OP_BRA    = 4'h4;
    localparam logic [3:0] OP_BRR    = 4'h5;
    localparam logic [3:0] OP_BNE    = 4'h6;
    localparam logic [3:0] OP_BNR    = 4'h7;
    localparam logic [3:0] OP_LOD    = 4'h8;
    localparam logic [3:0] OP_STR    = 4'h9;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [1:0] ALU_NONE = 2'b00;
    localparam logic [1:0] ALU_RR   = 2'b01;
    localparam logic [1:0] ALU_RI   = 2'b10;
    localparam logic [1:0] ALU_ADDR = 2'b11;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

endpackage

// File: rtl/sisc_mc_ctrl_br_cond.sv
// Branch-taken evaluation: BRA/BRR take on any masked status bit set,
// BNE/BNR take when none are set; non-branch opcodes never take.
module br_cond
    import sisc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BRA, OP_BRR: taken = |(stat & mm);
            OP_BNE, OP_BNR: taken = ~|(stat & mm);
            default:        taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/sisc_mc_ctrl.sv
// Multi-cycle SISC sequencing controller with a bounded req/ack data-memory handshake.
// Every control output is a flop loaded with the decode of the state being entered.
module sisc_mc_ctrl
    import sisc_pkg::*;
#(
    parameter int DM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_f,
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    input  logic       dm_ack,
    output logic       rf_we,
    output logic [1:0] alu_op,
    output logic       wb_sel,
    output logic       rb_sel,
    output logic       stat_en,
    output logic       pc_sel,
    output logic       pc_write,
    output logic       pc_rst,
    output logic       ir_load,
    output logic       br_sel,
    output logic       dm_req,
    output logic       dm_we,
    output logic       halted,
    output logic       bus_err
);

    localparam int CW = $clog2(DM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(DM_TIMEOUT);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          taken;

    logic       rf_we_q, rf_we_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic       wb_sel_q, wb_sel_d;
    logic       rb_sel_q, rb_sel_d;
    logic       stat_en_q, stat_en_d;
    logic       pc_sel_q, pc_sel_d;
    logic       pc_write_q, pc_write_d;
    logic       pc_rst_q, pc_rst_d;
    logic       ir_load_q, ir_load_d;
    logic       br_sel_q, br_sel_d;
    logic       dm_req_q, dm_req_d;
    logic       dm_we_q, dm_we_d;
    logic       halted_q, halted_d;
    logic       bus_err_q, bus_err_d;

    br_cond u_br_cond (
        .opcode (opcode),
        .mm     (mm),
        .stat   (stat),
        .taken  (taken)
    );

    assign cnt_inc = cnt_q + 1'b1;

    // Ack is checked before the limit so an ack in the final allowed cycle still completes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_LOD, OP_STR: begin
                        state_d = S_MEM;
                        cnt_d   = '0;
                    end
                    OP_ALU_RR, OP_ALU_RI: state_d = S_WB;
                    OP_HLT:               state_d = S_HALT;
                    default:              state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (dm_ack) begin
                    state_d = (opcode == OP_LOD) ? S_WB : S_FETCH;
                end else if (cnt_inc == LIMIT) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_RESET;
        endcase
    end

    // Decode keyed on the next state; the address-calc ALU op is held through MEM.
    always_comb begin
        rf_we_d    = 1'b0;
        alu_op_d   = ALU_NONE;
        wb_sel_d   = 1'b0;
        rb_sel_d   = 1'b0;
        stat_en_d  = 1'b0;
        pc_sel_d   = 1'b0;
        pc_write_d = 1'b0;
        pc_rst_d   = 1'b0;
        ir_load_d  = 1'b0;
        br_sel_d   = 1'b0;
        dm_req_d   = 1'b0;
        dm_we_d    = 1'b0;
        halted_d   = 1'b0;
        bus_err_d  = 1'b0;
        case (state_d)
            S_RESET: pc_rst_d = 1'b1;
            S_FETCH: begin
                ir_load_d  = 1'b1;
                pc_write_d = 1'b1;
            end
            S_EXEC: begin
                case (opcode)
                    OP_ALU_RR: begin
                        alu_op_d  = ALU_RR;
                        stat_en_d = 1'b1;
                    end
                    OP_ALU_RI: begin
                        alu_op_d  = ALU_RI;
                        stat_en_d = 1'b1;
                    end
                    OP_BRA, OP_BRR, OP_BNE, OP_BNR: begin
                        pc_sel_d   = taken;
                        pc_write_d = taken;
                        br_sel_d   = taken && (opcode == OP_BRA || opcode == OP_BNE);
                    end
                    OP_LOD: alu_op_d = ALU_ADDR;
                    OP_STR: begin
                        alu_op_d = ALU_ADDR;
                        rb_sel_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                alu_op_d = ALU_ADDR;
                dm_req_d = 1'b1;
                dm_we_d  = (opcode == OP_STR);
                rb_sel_d = (opcode == OP_STR);
            end
            S_WB: begin
                rf_we_d = 1'b1;
                if (opcode == OP_LOD) begin
                    wb_sel_d = 1'b1;
                end else begin
                    alu_op_d = (opcode == OP_ALU_RI) ? ALU_RI : ALU_RR;
                end
            end
            S_HALT: halted_d = 1'b1;
            S_ERR: begin
                halted_d  = 1'b1;
                bus_err_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q    <= S_RESET;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            alu_op_q   <= ALU_NONE;
            wb_sel_q   <= 1'b0;
            rb_sel_q   <= 1'b0;
            stat_en_q  <= 1'b0;
            pc_sel_q   <= 1'b0;
            pc_write_q <= 1'b0;
            pc_rst_q   <= 1'b1;
            ir_load_q  <= 1'b0;
            br_sel_q   <= 1'b0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            halted_q   <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            alu_op_q   <= alu_op_d;
            wb_sel_q   <= wb_sel_d;
            rb_sel_q   <= rb_sel_d;
            stat_en_q  <= stat_en_d;
            pc_sel_q   <= pc_sel_d;
            pc_write_q <= pc_write_d;
            pc_rst_q   <= pc_rst_d;
            ir_load_q  <= ir_load_d;
            br_sel_q   <= br_sel_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            halted_q   <= halted_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign alu_op   = alu_op_q;
    assign wb_sel   = wb_sel_q;
    assign rb_sel   = rb_sel_q;
    assign stat_en  = stat_en_q;
    assign pc_sel   = pc_sel_q;
    assign pc_write = pc_write_q;
    assign pc_rst   = pc_rst_q;
    assign ir_load  = ir_load_q;
    assign br_sel   = br_sel_q;
    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign halted   = halted_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_sisc_mc_ctrl.sv
// Directed bench for sisc_mc_ctrl: walks each instruction class cycle by cycle and
// compares the full control vector against hand-derived values.
module tb_sisc_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_f;
    logic [3:0] opcode, mm, stat;
    logic       dm_ack;
    logic       rf_we, wb_sel, rb_sel, stat_en, pc_sel, pc_write, pc_rst;
    logic       ir_load, br_sel, dm_req, dm_we, halted, bus_err;
    logic [1:0] alu_op;
    logic [14:0] ctl;

    int n_cmp  = 0;
    int n_fail = 0;

    // {rf_we, alu_op[1:0], wb_sel, rb_sel, stat_en, pc_sel, pc_write,
    //  pc_rst, ir_load, br_sel, dm_req, dm_we, halted, bus_err}
    localparam logic [14:0] E_RESET  = 15'h0040;
    localparam logic [14:0] E_FETCH  = 15'h00A0;
    localparam logic [14:0] E_IDLE   = 15'h0000;
    localparam logic [14:0] E_RR_EX  = 15'h1200;
    localparam logic [14:0] E_RR_WB  = 15'h5000;
    localparam logic [14:0] E_RI_EX  = 15'h2200;
    localparam logic [14:0] E_RI_WB  = 15'h6000;
    localparam logic [14:0] E_BR_ABS = 15'h0190;
    localparam logic [14:0] E_BR_REL = 15'h0180;
    localparam logic [14:0] E_LD_EX  = 15'h3000;
    localparam logic [14:0] E_LD_MEM = 15'h3008;
    localparam logic [14:0] E_LD_WB  = 15'h4800;
    localparam logic [14:0] E_ST_EX  = 15'h3400;
    localparam logic [14:0] E_ST_MEM = 15'h340C;
    localparam logic [14:0] E_HALT   = 15'h0002;
    localparam logic [14:0] E_ERR    = 15'h0003;

    sisc_mc_ctrl #(.DM_TIMEOUT(15)) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .dm_ack   (dm_ack),
        .rf_we    (rf_we),
        .alu_op   (alu_op),
        .wb_sel   (wb_sel),
        .rb_sel   (rb_sel),
        .stat_en  (stat_en),
        .pc_sel   (pc_sel),
        .pc_write (pc_write),
        .pc_rst   (pc_rst),
        .ir_load  (ir_load),
        .br_sel   (br_sel),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .halted   (halted),
        .bus_err  (bus_err)
    );

    assign ctl = {rf_we, alu_op, wb_sel, rb_sel, stat_en, pc_sel, pc_write,
                  pc_rst, ir_load, br_sel, dm_req, dm_we, halted, bus_err};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ctl(input string tag, input logic [14:0] exp);
        n_cmp++;
        assert (ctl === exp) else begin
            n_fail++;
            $error("FAIL %s: ctl=%h expected=%h", tag, ctl, exp);
        end
    endtask

    initial begin
        rst_f  = 1'b1;
        opcode = 4'h0;
        mm     = 4'h0;
        stat   = 4'h0;
        dm_ack = 1'b0;
        #1;
        expect_ctl("reset_async", E_RESET);
        tick();
        tick();
        expect_ctl("reset_held", E_RESET);
        rst_f = 1'b0;

        // NOP: FETCH, DECODE, EXEC, then FETCH again
        tick(); expect_ctl("nop_fetch", E_FETCH);
        tick(); expect_ctl("nop_decode", E_IDLE);
        tick(); expect_ctl("nop_exec", E_IDLE);
        tick(); expect_ctl("nop_next_fetch", E_FETCH);

        opcode = 4'h1;
        tick(); expect_ctl("rr_decode", E_IDLE);
        tick(); expect_ctl("rr_exec", E_RR_EX);
        tick(); expect_ctl("rr_wb", E_RR_WB);
        tick(); expect_ctl("rr_next_fetch", E_FETCH);

        opcode = 4'h2;
        tick(); tick(); expect_ctl("ri_exec", E_RI_EX);
        tick(); expect_ctl("ri_wb", E_RI_WB);
        tick(); expect_ctl("ri_next_fetch", E_FETCH);

        opcode = 4'h4; mm = 4'b0001; stat = 4'b0001;
        tick(); tick(); expect_ctl("bra_taken", E_BR_ABS);
        tick(); expect_ctl("bra_next_fetch", E_FETCH);

        opcode = 4'h4; mm = 4'b0000; stat = 4'b1111;
        tick(); tick(); expect_ctl("bra_mm0_not_taken", E_IDLE);
        tick(); expect_ctl("bra_mm0_fetch", E_FETCH);

        opcode = 4'h7; mm = 4'b0001; stat = 4'b0001;
        tick(); tick(); expect_ctl("bnr_not_taken", E_IDLE);
        tick(); expect_ctl("bnr_nt_fetch", E_FETCH);

        opcode = 4'h7; mm = 4'b0010; stat = 4'b0001;
        tick(); tick(); expect_ctl("bnr_taken_rel", E_BR_REL);
        tick(); expect_ctl("bnr_t_fetch", E_FETCH);

        opcode = 4'h6; mm = 4'b0000; stat = 4'b0101;
        tick(); tick(); expect_ctl("bne_mm0_taken", E_BR_ABS);
        tick(); expect_ctl("bne_fetch", E_FETCH);

        opcode = 4'h5; mm = 4'b1000; stat = 4'b1000;
        tick(); tick(); expect_ctl("brr_taken_rel", E_BR_REL);
        tick(); expect_ctl("brr_fetch", E_FETCH);

        // LOD, ack in the fourth MEM cycle: eight cycles FETCH to FETCH
        opcode = 4'h8; mm = 4'h0; stat = 4'h0;
        tick(); expect_ctl("lod_decode", E_IDLE);
        tick(); expect_ctl("lod_exec", E_LD_EX);
        tick(); expect_ctl("lod_mem1", E_LD_MEM);
        tick(); expect_ctl("lod_mem2", E_LD_MEM);
        tick(); expect_ctl("lod_mem3", E_LD_MEM);
        tick(); expect_ctl("lod_mem4", E_LD_MEM);
        dm_ack = 1'b1;
        tick(); expect_ctl("lod_wb", E_LD_WB);
        dm_ack = 1'b0;
        tick(); expect_ctl("lod_next_fetch", E_FETCH);

        // STR with ack already high outside MEM, then ack in first MEM cycle
        opcode = 4'h9; dm_ack = 1'b1;
        tick(); expect_ctl("str_decode_ack_ignored", E_IDLE);
        dm_ack = 1'b0;
        tick(); expect_ctl("str_exec", E_ST_EX);
        tick(); expect_ctl("str_mem1", E_ST_MEM);
        dm_ack = 1'b1;
        tick(); expect_ctl("str_w0_fetch", E_FETCH);
        dm_ack = 1'b0;

        // STR with ack on the last permitted cycle: ack beats the timeout
        tick(); tick();
        for (int i = 1; i <= 15; i++) begin
            tick(); expect_ctl($sformatf("str_edge_mem%0d", i), E_ST_MEM);
        end
        dm_ack = 1'b1;
        tick(); expect_ctl("str_ack_wins", E_FETCH);
        dm_ack = 1'b0;

        // STR never acked: 15 MEM cycles then ERR
        tick(); tick();
        for (int i = 1; i <= 15; i++) begin
            tick(); expect_ctl($sformatf("str_to_mem%0d", i), E_ST_MEM);
        end
        tick(); expect_ctl("str_timeout_err", E_ERR);
        tick(); tick(); tick();
        dm_ack = 1'b1;
        tick(); expect_ctl("err_sticky", E_ERR);
        dm_ack = 1'b0;
        rst_f = 1'b1;
        #1; expect_ctl("err_reset_clears", E_RESET);
        tick();
        rst_f = 1'b0;
        opcode = 4'hF;
        tick(); expect_ctl("post_err_fetch", E_FETCH);

        // HLT: halted persists, no further fetches
        tick(); tick(); expect_ctl("hlt_exec", E_IDLE);
        tick(); expect_ctl("hlt_halt", E_HALT);
        for (int i = 0; i < 20; i++) begin
            tick(); expect_ctl($sformatf("halt_hold%0d", i), E_HALT);
        end
        rst_f = 1'b1;
        #1; expect_ctl("halt_reset", E_RESET);
        tick();
        rst_f = 1'b0;
        opcode = 4'h8;
        tick(); expect_ctl("post_halt_fetch", E_FETCH);

        // Reset mid-LOD MEM: dm_req drops at once, no WB follows
        tick(); tick();
        tick(); expect_ctl("lod2_mem1", E_LD_MEM);
        tick(); expect_ctl("lod2_mem2", E_LD_MEM);
        #2 rst_f = 1'b1;
        #1; expect_ctl("lod2_async_reset", E_RESET);
        tick();
        rst_f = 1'b0;
        opcode = 4'h0;
        tick(); expect_ctl("lod2_restart_fetch", E_FETCH);
        tick(); expect_ctl("lod2_restart_decode", E_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sisc_mc_ctrl.md
# sisc_mc_ctrl

Multi-cycle sequencing controller for the SISC datapath, extended with data-memory load/store sequencing. It steps each instruction through fetch, decode, execute, optional memory and writeback phases, and drives every datapath control: register file, ALU, status register, PC, IR and branch mux. It also runs a req/ack handshake to a variable-latency data memory, with a bounded wait.

## Interface
- `DM_TIMEOUT`, 15: maximum cycles `dm_req` may wait for `dm_ack` before bus error (1..255).
- `clk` in 1: sole clock, all state on rising edge.
- `rst_f` in 1: asynchronous, active-high reset.
- `opcode` in 4: IR[31:28].
- `mm` in 4: IR[27:24]; branch condition mask / ALU sub-mode.
- `stat` in 4: status register {C,V,N,Z}.
- `dm_ack` in 1: data memory completed current access.
- `rf_we` out 1: register-file write enable.
- `alu_op` out 2: 00 pass/none, 01 reg-reg, 10 reg-imm, 11 address calc.
- `wb_sel` out 1: 0 = ALU result, 1 = memory read data.
- `rb_sel` out 1: 1 selects IR[23:20] as read port B (store data).
- `stat_en` out 1: status register load.
- `pc_sel` out 1: 1 = branch target, 0 = PC+1.
- `pc_write` out 1: PC load.
- `pc_rst` out 1: PC clear.
- `ir_load` out 1: IR load.
- `br_sel` out 1: 1 = absolute target, 0 = PC-relative.
- `dm_req` out 1: memory access request.
- `dm_we` out 1: qualifies `dm_req` as store.
- `halted` out 1: controller stopped.
- `bus_err` out 1: sticky, memory timeout occurred.

## Operation
- **Opcodes:**
  - 0 NOP
  - 1 ALU reg-reg
  - 2 ALU reg-imm
  - 4 BRA (absolute)
  - 5 BRR (relative)
  - 6 BNE (absolute)
  - 7 BNR (relative)
  - 8 LOD
  - 9 STR
  - F HLT
  - Others execute as NOP.
- **States:** RESET, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- **RESET:** entered asynchronously. Asserts `pc_rst`; all other outputs 0; `bus_err` cleared. Next state is FETCH.
- **FETCH:** `ir_load`=1, `pc_write`=1, `pc_sel`=0. Next state is DECODE.
- **DECODE:** no outputs asserted (register read settles). Next state is EXEC.
- **EXEC:**
  - ALU (1, 2): `alu_op`=01/10, `stat_en`=1.
  - Branch taken condition:
    - BRA/BRR: (stat & mm) != 0.
    - BNE/BNR: (stat & mm) == 0.
    - mm = 0 means BRA/BRR never taken, BNE/BNR always taken.
  - Taken branch: `pc_sel`=1, `pc_write`=1, `br_sel`=1 for 4/6, 0 for 5/7.
  - LOD/STR: `alu_op`=11; STR also `rb_sel`=1.
  - HLT: next state is HALT.
  - Next state: MEM for 8/9; WB for 1/2; FETCH otherwise.
- **MEM:**
  - `dm_req`=1 (plus `dm_we`=1 for STR, and `rb_sel` held) until `dm_ack` is sampled high.
  - On ack: LOD goes to WB; STR goes to FETCH.
  - A wait counter increments each MEM cycle without ack. At count = DM_TIMEOUT, next state is ERR.
  - Ack on the same cycle the limit is reached: ack wins.
- **WB:** `rf_we`=1. `wb_sel`=1 for LOD, else 0 with `alu_op` held. Next state is FETCH.
- **HALT:** `halted`=1; all controls 0. Left only by reset.
- **ERR:** `halted`=1, `bus_err`=1; `dm_req` dropped. Left only by reset.
- Status register is written only in EXEC of ALU ops. Branches, loads and stores leave it unchanged.

## Timing
- Outputs are decoded from registered state and the registered IR fields (no input-to-output comb path except condition evaluation in EXEC).
- **Cycle counts:**
  - NOP/branch: 3 (FETCH, DECODE, EXEC).
  - ALU: 4.
  - STR: 4+W.
  - LOD: 5+W.
  - W = cycles of `dm_req` high before `dm_ack` (W ≥ 0 counts ack in the first MEM cycle as 0 waits).
- `dm_req`/`dm_we` are stable from the first MEM cycle through the ack cycle and deassert in the cycle after ack.
- `dm_ack` outside MEM is ignored.
- Reset mid-access: `dm_req` falls asynchronously with reset; the wait counter clears; no RF write occurs.
- Wait counter width: ceil(log2(DM_TIMEOUT+1)); cleared on MEM entry.

## Structure
- Shared package `sisc_pkg` holds:
  - opcode constants (NOP, ALU_RR, ALU_RI, BRA, BRR, BNE, BNR, LOD, STR, HLT);
  - `alu_op` encodings;
  - the state enumeration.
- One sub-module, `br_cond`: combinational taken evaluation from opcode, mm, stat.
- The FSM, the wait counter and output decode live in `sisc_mc_ctrl`.

## Test plan
- **Reset, then NOP:** `rst_f` pulse → `pc_rst`=1 during RESET; `ir_load` and `pc_write` high on the cycle after; instruction completes in 3 cycles.
- **ALU reg-reg (opcode 1):** `stat_en`=1 in EXEC, `rf_we`=1 with `wb_sel`=0 in WB; next FETCH exactly 4 cycles after previous FETCH.
- **Branches:**
  - BRA, mm=0001, stat=0001 → `pc_sel`=1, `br_sel`=1, `pc_write`=1 in EXEC.
  - BNR, mm=0001, stat=0001 → no `pc_write` in EXEC.
- **LOD with `dm_ack` after 3 wait cycles:** `dm_req` high 4 cycles, `dm_we`=0; WB with `wb_sel`=1, `rf_we`=1; total 8 cycles.
- **STR with `dm_ack` never asserted, DM_TIMEOUT=15:** ERR entered after 15 MEM cycles; `bus_err`=1, `halted`=1, `dm_req`=0. Reset then clears `bus_err`.
- **HLT, then reset:** `halted` stays 1 for 20 cycles with no `ir_load`. `rst_f` asserted mid-LOD MEM drops `dm_req` immediately and restarts at FETCH with no RF write.
